// File: rtl/alarm_key_controller.sv
// Keypad sequencing FSM for the alarm clock: collects HH:MM digits, validates them and
// pulses the counter/alarm load strobes, with an inactivity timeout on entry and alarm display.
module alarm_key_controller #(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic       key_pressed,
  input  logic [3:0] key_code,
  output logic [3:0] new_time_ms_hr,
  output logic [3:0] new_time_ls_hr,
  output logic [3:0] new_time_ms_min,
  output logic [3:0] new_time_ls_min,
  output logic       load_new_c,
  output logic       load_new_a,
  output logic       show_new_time,
  output logic       show_a,
  output logic       entry_error
);

  localparam int TW = $clog2(TIMEOUT_SEC + 1);

  typedef enum logic [2:0] {
    IDLE,
    SHOW_ALARM,
    KEY_ENTRY,
    SET_ALARM_TIME,
    SET_CURRENT_TIME
  } state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [3:0]      ms_hr_next, ls_hr_next, ms_min_next, ls_min_next;
  logic            load_c_next, load_a_next, error_next;
  logic            show_new_time_next, show_a_next;
  logic            is_digit, is_alarm, is_time, tick_expire, buf_valid;

  always_comb begin
    is_digit    = key_pressed && (key_code <= 4'd9);
    is_alarm    = key_pressed && (key_code == 4'd10);
    is_time     = key_pressed && (key_code == 4'd11);
    tick_expire = one_second && (timer_reg == TW'(TIMEOUT_SEC - 1));
    buf_valid   = (new_time_ms_hr <= 4'd2) && (new_time_ls_hr <= 4'd9) &&
                  !((new_time_ms_hr == 4'd2) && (new_time_ls_hr > 4'd3)) &&
                  (new_time_ms_min <= 4'd5) && (new_time_ls_min <= 4'd9);

    state_next  = state_reg;
    timer_next  = '0;
    ms_hr_next  = new_time_ms_hr;
    ls_hr_next  = new_time_ls_hr;
    ms_min_next = new_time_ms_min;
    ls_min_next = new_time_ls_min;
    load_c_next = 1'b0;
    load_a_next = 1'b0;
    error_next  = 1'b0;

    // The buffer stays readable while the load/error pulse is visible, then clears.
    if (load_new_c || load_new_a || entry_error) begin
      ms_hr_next  = 4'd0;
      ls_hr_next  = 4'd0;
      ms_min_next = 4'd0;
      ls_min_next = 4'd0;
    end

    case (state_reg)
      IDLE: begin
        if (is_digit) begin
          ms_hr_next  = 4'd0;
          ls_hr_next  = 4'd0;
          ms_min_next = 4'd0;
          ls_min_next = key_code;
          state_next  = KEY_ENTRY;
        end else if (is_alarm) begin
          state_next = SHOW_ALARM;
        end
      end
      SHOW_ALARM: begin
        timer_next = timer_reg + TW'(one_second);
        if (is_alarm || tick_expire) begin
          state_next = IDLE;
          timer_next = '0;
        end
      end
      KEY_ENTRY: begin
        timer_next = timer_reg + TW'(one_second);
        if (is_digit) begin
          ms_hr_next  = new_time_ls_hr;
          ls_hr_next  = new_time_ms_min;
          ms_min_next = new_time_ls_min;
          ls_min_next = key_code;
          timer_next  = '0;
        end else if (is_alarm) begin
          state_next = SET_ALARM_TIME;
          timer_next = '0;
        end else if (is_time) begin
          state_next = SET_CURRENT_TIME;
          timer_next = '0;
        end else if (tick_expire) begin
          state_next  = IDLE;
          timer_next  = '0;
          ms_hr_next  = 4'd0;
          ls_hr_next  = 4'd0;
          ms_min_next = 4'd0;
          ls_min_next = 4'd0;
        end
      end
      SET_ALARM_TIME: begin
        load_a_next = buf_valid;
        error_next  = !buf_valid;
        state_next  = IDLE;
      end
      SET_CURRENT_TIME: begin
        load_c_next = buf_valid;
        error_next  = !buf_valid;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase

    show_new_time_next = (state_next == KEY_ENTRY);
    show_a_next        = (state_next == SHOW_ALARM);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      timer_reg       <= '0;
      new_time_ms_hr  <= 4'd0;
      new_time_ls_hr  <= 4'd0;
      new_time_ms_min <= 4'd0;
      new_time_ls_min <= 4'd0;
      load_new_c      <= 1'b0;
      load_new_a      <= 1'b0;
      entry_error     <= 1'b0;
      show_new_time   <= 1'b0;
      show_a          <= 1'b0;
    end else begin
      state_reg       <= state_next;
      timer_reg       <= timer_next;
      new_time_ms_hr  <= ms_hr_next;
      new_time_ls_hr  <= ls_hr_next;
      new_time_ms_min <= ms_min_next;
      new_time_ls_min <= ls_min_next;
      load_new_c      <= load_c_next;
      load_new_a      <= load_a_next;
      entry_error     <= error_next;
      show_new_time   <= show_new_time_next;
      show_a          <= show_a_next;
    end
  end

endmodule

// File: tb/tb_alarm_key_controller.sv
// Directed bench for alarm_key_controller: entry, load/validation, timeout and reset abort.
module tb_alarm_key_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       one_second;
  logic       key_pressed;
  logic [3:0] key_code;
  logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
  logic       load_new_c, load_new_a, show_new_time, show_a, entry_error;

  int vectors = 0;
  int miscompares = 0;

  alarm_key_controller #(.TIMEOUT_SEC(10)) dut (
    .clk            (clk),
    .reset          (reset),
    .one_second     (one_second),
    .key_pressed    (key_pressed),
    .key_code       (key_code),
    .new_time_ms_hr (ms_hr),
    .new_time_ls_hr (ls_hr),
    .new_time_ms_min(ms_min),
    .new_time_ls_min(ls_min),
    .load_new_c     (load_new_c),
    .load_new_a     (load_new_a),
    .show_new_time  (show_new_time),
    .show_a         (show_a),
    .entry_error    (entry_error)
  );

  always #5 clk = ~clk;

  // {load_new_c, load_new_a, entry_error, show_new_time, show_a}
  function automatic logic [4:0] flags();
    return {load_new_c, load_new_a, entry_error, show_new_time, show_a};
  endfunction

  function automatic logic [15:0] bufv();
    return {ms_hr, ls_hr, ms_min, ls_min};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("vector %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
  endtask

  // One-cycle strobe, optionally with a coincident one_second tick; returns at the next negedge.
  task automatic strobe(input bit key, input logic [3:0] code, input bit tick);
    @(negedge clk);
    key_pressed = key;
    key_code    = code;
    one_second  = tick;
    @(negedge clk);
    key_pressed = 1'b0;
    key_code    = 4'd0;
    one_second  = 1'b0;
  endtask

  task automatic key(input logic [3:0] code);
    strobe(1'b1, code, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) strobe(1'b0, 4'd0, 1'b1);
  endtask

  initial begin
    reset = 1'b0; one_second = 1'b0; key_pressed = 1'b0; key_code = 4'd0;
    repeat (2) @(negedge clk);
    chk("reset_flags", 16'(flags()), 16'h0000);
    chk("reset_buf", bufv(), 16'h0000);
    reset = 1'b1;

    // Reset mid-entry is asynchronous and clears everything.
    key(4'd0); key(4'd1); key(4'd2);
    chk("entry_0012", bufv(), 16'h0012);
    chk("entry_show", 16'(flags()), 16'h0002);
    reset = 1'b0;
    #1;
    chk("async_rst_buf", bufv(), 16'h0000);
    chk("async_rst_flags", 16'(flags()), 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    key(4'd11);
    chk("time_in_idle", 16'(flags()), 16'h0000);
    @(negedge clk);
    chk("post_rst_noload", 16'(flags()), 16'h0000);

    // Reset during the SET cycle aborts the load.
    key(4'd1); key(4'd2); key(4'd11);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("set_rst_noload", 16'(flags()), 16'h0000);
    chk("set_rst_buf", bufv(), 16'h0000);

    // 09:59 -> current time load
    key(4'd0); key(4'd9); key(4'd5); key(4'd9);
    chk("buf_0959", bufv(), 16'h0959);
    key(4'd11);
    chk("set_c_cycle", 16'(flags()), 16'h0000);
    @(negedge clk);
    chk("load_c_pulse", 16'(flags()), 16'h0010);
    chk("load_c_buf", bufv(), 16'h0959);
    @(negedge clk);
    chk("load_c_end", 16'(flags()), 16'h0000);
    chk("buf_cleared", bufv(), 16'h0000);

    // 23:59 -> alarm load
    key(4'd2); key(4'd3); key(4'd5); key(4'd9); key(4'd10);
    chk("set_a_cycle", 16'(flags()), 16'h0000);
    @(negedge clk);
    chk("load_a_pulse", 16'(flags()), 16'h0008);
    chk("load_a_buf", bufv(), 16'h2359);
    @(negedge clk);
    chk("load_a_end", 16'(flags()), 16'h0000);

    // Five digits: oldest discarded
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    chk("buf_2345", bufv(), 16'h2345);
    key(4'd11); @(negedge clk);
    chk("load_2345", 16'(flags()), 16'h0010);

    // 24:00 invalid
    key(4'd2); key(4'd4); key(4'd0); key(4'd0); key(4'd11); @(negedge clk);
    chk("err_2400", 16'(flags()), 16'h0004);
    @(negedge clk);
    chk("err_2400_end", 16'(flags()), 16'h0000);

    // 00:60 invalid
    key(4'd0); key(4'd0); key(4'd6); key(4'd0); key(4'd11); @(negedge clk);
    chk("err_0060", 16'(flags()), 16'h0004);

    // Entry timeout after 10 ticks
    @(negedge clk);
    key(4'd7);
    ticks(9);
    chk("to9_still_entry", 16'(flags()), 16'h0002);
    chk("to9_buf", bufv(), 16'h0007);
    ticks(1);
    chk("to10_idle", 16'(flags()), 16'h0000);
    chk("to10_buf", bufv(), 16'h0000);

    // Digit coincident with the expiring tick wins and restarts the timer
    key(4'd7);
    ticks(9);
    strobe(1'b1, 4'd3, 1'b1);
    chk("key_wins", 16'(flags()), 16'h0002);
    chk("key_wins_buf", bufv(), 16'h0073);
    ticks(9);
    chk("restart9_entry", 16'(flags()), 16'h0002);
    ticks(1);
    chk("restart10_idle", 16'(flags()), 16'h0000);

    // Alarm display
    key(4'd10);
    chk("show_a_on", 16'(flags()), 16'h0001);
    key(4'd5);
    chk("show_a_digit_ign", 16'(flags()), 16'h0001);
    key(4'd13);
    chk("show_a_13_ign", 16'(flags()), 16'h0001);
    key(4'd10);
    chk("show_a_off", 16'(flags()), 16'h0000);
    key(4'd10);
    ticks(9);
    chk("show_a_to9", 16'(flags()), 16'h0001);
    ticks(1);
    chk("show_a_to10", 16'(flags()), 16'h0000);

    // Ignored code 13 in IDLE and KEY_ENTRY
    key(4'd13);
    chk("idle_13_ign", 16'(flags()), 16'h0000);
    key(4'd4); key(4'd13);
    chk("entry_13_ign", bufv(), 16'h0004);
    chk("entry_13_show", 16'(flags()), 16'h0002);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alarm_key_controller.md
Name: alarm_key_controller

Overview:
- Control FSM for the digital alarm clock. Sequences keypad entry into a 4-digit HH:MM buffer.
- Drives the time counter's load_new_c and the alarm register's load_new_a.
- Drives display-select flags show_new_time and show_a.
- Applies an inactivity timeout to entry and alarm-display modes, counted from the one_second tick.

Parameters:
- TIMEOUT_SEC, 10: number of one_second ticks without an accepted key before KEY_ENTRY or SHOW_ALARM returns to IDLE.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- one_second  in  1  single-cycle tick, once per second
- key_pressed  in  1  single-cycle strobe qualifying key_code
- key_code  in  4  0-9 digits; 10 = ALARM; 11 = TIME; 12-15 ignored
- new_time_ms_hr  out  4  entry buffer, hours tens digit
- new_time_ls_hr  out  4  entry buffer, hours units digit
- new_time_ms_min  out  4  entry buffer, minutes tens digit
- new_time_ls_min  out  4  entry buffer, minutes units digit
- load_new_c  out  1  one-cycle pulse; counter loads the buffer
- load_new_a  out  1  one-cycle pulse; alarm register loads the buffer
- show_new_time  out  1  display shows the entry buffer
- show_a  out  1  display shows the alarm time
- entry_error  out  1  one-cycle pulse; load rejected because the buffer is not a valid 24 h time

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous):
  - state = IDLE, buffer = 0000, timeout counter = 0.
  - All 1-bit outputs = 0.
  - Reset mid-entry or during a SET state aborts with no load pulse.
- An accepted key is key_pressed=1 with key_code 0-11. Codes 12-15 cause no state change and no timer reset.
- States: IDLE, SHOW_ALARM, KEY_ENTRY, SET_ALARM_TIME, SET_CURRENT_TIME.
- IDLE:
  - show_new_time=0, show_a=0.
  - Digit d: buffer <= 000d, go to KEY_ENTRY.
  - ALARM: go to SHOW_ALARM.
  - TIME: ignored.
- SHOW_ALARM:
  - show_a=1.
  - ALARM: go to IDLE.
  - Digits and TIME: ignored, no timer reset.
  - Timeout: go to IDLE.
- KEY_ENTRY:
  - show_new_time=1.
  - Digit d: shift left one digit. ms_hr<=ls_hr, ls_hr<=ms_min, ms_min<=ls_min, ls_min<=d. The oldest digit is discarded; unlimited digits are allowed.
  - ALARM: go to SET_ALARM_TIME.
  - TIME: go to SET_CURRENT_TIME.
  - Timeout: go to IDLE, buffer <= 0000.
- SET_ALARM_TIME / SET_CURRENT_TIME:
  - Resident exactly one cycle, then go to IDLE.
  - If the buffer is valid, load_new_a / load_new_c = 1 for that cycle.
  - If invalid, no load and entry_error = 1 for that cycle instead.
  - Valid means: ms_hr<=2; ls_hr<=9, and ls_hr<=3 when ms_hr=2; ms_min<=5; ls_min<=9.
  - Buffer is held stable during the SET cycle and cleared to 0000 on the following edge.
  - Keys arriving during the SET cycle are dropped.
- Latency: a key strobe sampled at edge N takes effect at edge N, so state, buffer and outputs change after edge N. load pulse is high from edge N+1 to N+2 after the ALARM/TIME strobe.
- Timeout counter:
  - Width $clog2(TIMEOUT_SEC+1).
  - Cleared on entry to SHOW_ALARM or KEY_ENTRY and on every accepted digit in KEY_ENTRY.
  - Increments on one_second while in those states.
  - Timeout fires on a one_second tick with counter = TIMEOUT_SEC-1.
  - Held at 0 in other states.
- Simultaneous accepted key and timeout-firing tick: the key wins and the timer clears.
- key_pressed held high for several cycles counts as one press per cycle. The upstream debouncer guarantees single-cycle strobes.

Test Plan:
- Reset with reset=0 mid-KEY_ENTRY (buffer 0012) -> all outputs 0, buffer 0000, state IDLE. No load pulse after reset=1.
- Keys 0,9,5,9 then TIME -> buffer reads 0959 before TIME. load_new_c=1 for exactly one cycle, one edge after the TIME strobe, with outputs ms_hr=0, ls_hr=9, ms_min=5, ls_min=9. Buffer becomes 0000 next cycle; show_new_time falls.
- Keys 2,3,5,9 then ALARM -> load_new_a single pulse with buffer 2359; load_new_c stays 0.
- Keys 1,2,3,4,5 then TIME -> buffer 2345 and load_new_c pulse. Keys 2,4,0,0 then TIME -> entry_error pulse and no load_new_c. Keys 0,0,6,0 then TIME -> entry_error.
- Key 7, then 10 one_second ticks with no key -> return to IDLE on the 10th tick, buffer 0000, no load. Repeat with a digit on tick 9 -> timer restarts; a further 10 ticks are needed.
- ALARM from IDLE -> show_a=1. Digit 5 is ignored. A second ALARM -> IDLE. ALARM followed by 10 ticks -> show_a=0 after the 10th tick. Key_code 13 strobes in any state -> no effect.
